// File: rtl/pgm_ddram_pkg.sv
// Shared types and constants for the PGM DDRAM request port.
package pgm_ddram_pkg;

  localparam int unsigned ADDR_W = 29;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned BE_W   = 8;

  // Avalon burst count: every transaction is a single beat.
  localparam logic [7:0] BURST_ONE = 8'd1;

  typedef enum logic [2:0] {
    IDLE,
    WR_ISSUE,
    RD_ISSUE,
    RD_WAIT,
    RD_DONE
  } state_t;

  // One posted write: address, data and byte enables (101 bits).
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic [BE_W-1:0]   be;
  } wr_entry_t;

endpackage

// File: rtl/pgm_ddram_port_wr_fifo.sv
// Posted-write FIFO; the head entry stays in place until the Avalon write is accepted.
module pgm_wr_fifo
  import pgm_ddram_pkg::*;
#(
  parameter int unsigned WR_DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  logic      pop,
  input  wr_entry_t din,
  output logic      full,
  output logic      empty,
  output wr_entry_t head
);

  localparam int unsigned PTR_W = (WR_DEPTH > 1) ? $clog2(WR_DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(WR_DEPTH);

  wr_entry_t        mem [WR_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage, no reset needed since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/pgm_ddram_port.sv
// Core-side DDRAM responder: posted writes through a FIFO, serialised single reads,
// each turned into one single-beat Avalon transaction.
module pgm_ddram_port
  import pgm_ddram_pkg::*;
#(
  parameter int unsigned WR_DEPTH = 4
) (
  input  logic        fixed_50m_clk,
  input  logic        reset,
  input  logic        ddram_rd,
  input  logic        ddram_we,
  input  logic [28:0] ddram_addr,
  input  logic [63:0] ddram_din,
  input  logic [7:0]  ddram_be,
  output logic [63:0] ddram_dout,
  output logic        ddram_dout_ready,
  output logic        ddram_busy,
  output logic        wr_overflow,
  input  logic        DDRAM_BUSY,
  output logic [7:0]  DDRAM_BURSTCNT,
  output logic [28:0] DDRAM_ADDR,
  output logic        DDRAM_RD,
  output logic        DDRAM_WE,
  output logic [63:0] DDRAM_DIN,
  output logic [7:0]  DDRAM_BE,
  input  logic [63:0] DDRAM_DOUT,
  input  logic        DDRAM_DOUT_READY
);

  state_t      state;
  state_t      state_next;
  logic        discard;
  logic        push;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  wr_entry_t   fifo_head;
  wr_entry_t   in_entry;
  wr_entry_t   issue;
  logic        we_next;
  logic        rd_next;
  logic [28:0] addr_next;
  logic [63:0] din_next;
  logic [7:0]  be_next;
  logic [63:0] dout_next;
  logic        ready_next;

  assign in_entry       = '{addr: ddram_addr, din: ddram_din, be: ddram_be};
  assign push           = ddram_we && !fifo_full;
  assign DDRAM_BURSTCNT = BURST_ONE;
  assign ddram_busy     = fifo_full || (state inside {RD_ISSUE, RD_WAIT, RD_DONE});

  pgm_wr_fifo #(
    .WR_DEPTH(WR_DEPTH)
  ) u_wr_fifo (
    .clk   (fixed_50m_clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (in_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  // Next state and next Avalon/return register values; writes always win over a read in IDLE.
  always_comb begin
    state_next = state;
    we_next    = DDRAM_WE;
    rd_next    = DDRAM_RD;
    addr_next  = DDRAM_ADDR;
    din_next   = DDRAM_DIN;
    be_next    = DDRAM_BE;
    dout_next  = ddram_dout;
    ready_next = 1'b0;
    pop        = 1'b0;
    // An entry being pushed into an empty FIFO is issued straight from the inputs.
    issue      = fifo_empty ? in_entry : fifo_head;
    case (state)
      IDLE: begin
        if (!fifo_empty || push) begin
          state_next = WR_ISSUE;
          we_next    = 1'b1;
          addr_next  = issue.addr;
          din_next   = issue.din;
          be_next    = issue.be;
        end else if (ddram_rd && !discard) begin
          state_next = RD_ISSUE;
          rd_next    = 1'b1;
          addr_next  = ddram_addr;
        end
      end
      WR_ISSUE: begin
        if (!DDRAM_BUSY) begin
          pop        = 1'b1;
          we_next    = 1'b0;
          state_next = IDLE;
        end
      end
      RD_ISSUE: begin
        if (!DDRAM_BUSY) begin
          rd_next    = 1'b0;
          state_next = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (DDRAM_DOUT_READY) begin
          dout_next  = DDRAM_DOUT;
          ready_next = 1'b1;
          state_next = RD_DONE;
        end
      end
      RD_DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge fixed_50m_clk) begin
    if (reset) begin
      state            <= IDLE;
      DDRAM_WE         <= 1'b0;
      DDRAM_RD         <= 1'b0;
      DDRAM_ADDR       <= '0;
      DDRAM_DIN        <= '0;
      DDRAM_BE         <= '0;
      ddram_dout       <= '0;
      ddram_dout_ready <= 1'b0;
    end else begin
      state            <= state_next;
      DDRAM_WE         <= we_next;
      DDRAM_RD         <= rd_next;
      DDRAM_ADDR       <= addr_next;
      DDRAM_DIN        <= din_next;
      DDRAM_BE         <= be_next;
      ddram_dout       <= dout_next;
      ddram_dout_ready <= ready_next;
    end
  end

  // Sticky flag for writes dropped because the FIFO was full.
  always_ff @(posedge fixed_50m_clk) begin
    if (reset)                       wr_overflow <= 1'b0;
    else if (ddram_we && fifo_full)  wr_overflow <= 1'b1;
  end

  // Remember a read still in flight at the memory across reset so its data is swallowed.
  always_ff @(posedge fixed_50m_clk) begin
    if (reset) begin
      discard <= ((state == RD_WAIT) && !DDRAM_DOUT_READY) ||
                 ((state == RD_ISSUE) && !DDRAM_BUSY) ||
                 (discard && !DDRAM_DOUT_READY);
    end else if (DDRAM_DOUT_READY) begin
      discard <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pgm_ddram_port.sv
// Randomised self-checking bench for pgm_ddram_port with an Avalon memory model.
module tb_pgm_ddram_port;

  localparam int unsigned DEPTH = 4;

  typedef struct { logic [28:0] addr; logic [63:0] din; logic [7:0] be; } wr_t;
  typedef struct { logic [28:0] addr; int due; } pend_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ddram_rd = 1'b0;
  logic        ddram_we = 1'b0;
  logic [28:0] ddram_addr = '0;
  logic [63:0] ddram_din = '0;
  logic [7:0]  ddram_be = '0;
  logic [63:0] ddram_dout;
  logic        ddram_dout_ready;
  logic        ddram_busy;
  logic        wr_overflow;
  logic        DDRAM_BUSY = 1'b0;
  logic [7:0]  DDRAM_BURSTCNT;
  logic [28:0] DDRAM_ADDR;
  logic        DDRAM_RD;
  logic        DDRAM_WE;
  logic [63:0] DDRAM_DIN;
  logic [7:0]  DDRAM_BE;
  logic [63:0] DDRAM_DOUT = '0;
  logic        DDRAM_DOUT_READY = 1'b0;

  pgm_ddram_port #(.WR_DEPTH(DEPTH)) dut (
    .fixed_50m_clk    (clk),
    .reset            (reset),
    .ddram_rd         (ddram_rd),
    .ddram_we         (ddram_we),
    .ddram_addr       (ddram_addr),
    .ddram_din        (ddram_din),
    .ddram_be         (ddram_be),
    .ddram_dout       (ddram_dout),
    .ddram_dout_ready (ddram_dout_ready),
    .ddram_busy       (ddram_busy),
    .wr_overflow      (wr_overflow),
    .DDRAM_BUSY       (DDRAM_BUSY),
    .DDRAM_BURSTCNT   (DDRAM_BURSTCNT),
    .DDRAM_ADDR       (DDRAM_ADDR),
    .DDRAM_RD         (DDRAM_RD),
    .DDRAM_WE         (DDRAM_WE),
    .DDRAM_DIN        (DDRAM_DIN),
    .DDRAM_BE         (DDRAM_BE),
    .DDRAM_DOUT       (DDRAM_DOUT),
    .DDRAM_DOUT_READY (DDRAM_DOUT_READY)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // Requester-view memory, memory-side contents, and outstanding expectations.
  logic [63:0] model_mem [logic [28:0]];
  logic [63:0] slave_mem [logic [28:0]];
  wr_t         exp_wr [$];
  logic [63:0] exp_rd [$];
  pend_t       pend [$];

  int busy_mode = 0;     // 0: never busy, 1: random, 2: always busy
  int lat_fixed = 0;     // 0: random read latency 1..4
  int rd_accepts = 0;
  int rd_high_cnt = 0;
  int ready_cnt = 0;
  int ready_cyc = 0;
  int slave_rdy_cyc = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] dflt(input logic [28:0] a);
    return {3'b000, a, 3'b000, a} ^ 64'hA5A5_0000_5A5A_0000;
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                        input logic [7:0] b);
    logic [63:0] r;
    r = old;
    for (int k = 0; k < 8; k++) if (b[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  function automatic logic [63:0] model_rd(input logic [28:0] a);
    return model_mem.exists(a) ? model_mem[a] : dflt(a);
  endfunction

  function automatic logic [63:0] slave_rd(input logic [28:0] a);
    return slave_mem.exists(a) ? slave_mem[a] : dflt(a);
  endfunction

  // Avalon memory: drives waitrequest and returns read data after a latency.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      DDRAM_DOUT_READY = 1'b0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        DDRAM_DOUT       = slave_rd(pend[0].addr);
        DDRAM_DOUT_READY = 1'b1;
        slave_rdy_cyc    = cyc;
        void'(pend.pop_front());
      end
      case (busy_mode)
        1:       DDRAM_BUSY = ($urandom_range(3) == 0);
        2:       DDRAM_BUSY = 1'b1;
        default: DDRAM_BUSY = 1'b0;
      endcase
    end
  end

  // Mid-cycle observer: Avalon stability, write order, read ordering and returned data.
  logic [102:0] hold_snap = '0;
  bit           hold_valid = 0;
  logic         rd_prev = 1'b0;
  always @(negedge clk) begin
    logic [102:0] cur;
    wr_t w;
    cur = {DDRAM_WE, DDRAM_RD, DDRAM_ADDR, DDRAM_DIN, DDRAM_BE};
    if (hold_valid) check("av_stable", 128'(cur), 128'(hold_snap));
    hold_valid = (DDRAM_WE || DDRAM_RD) && DDRAM_BUSY && !reset;
    hold_snap  = cur;
    if (DDRAM_RD && !rd_prev) begin
      check("rd_after_writes", 128'(exp_wr.size()), 128'(0));
      check("rd_serial", 128'(pend.size()), 128'(0));
    end
    rd_prev = DDRAM_RD;
    if (DDRAM_RD) rd_high_cnt++;
    if (DDRAM_WE && !DDRAM_BUSY) begin
      if (exp_wr.size() == 0) begin
        check("wr_unexpected", 128'(1), 128'(0));
      end else begin
        w = exp_wr.pop_front();
        check("wr_addr", 128'(DDRAM_ADDR), 128'(w.addr));
        check("wr_din", 128'(DDRAM_DIN), 128'(w.din));
        check("wr_be", 128'(DDRAM_BE), 128'(w.be));
      end
      slave_mem[DDRAM_ADDR] = merge(slave_rd(DDRAM_ADDR), DDRAM_DIN, DDRAM_BE);
    end
    if (DDRAM_RD && !DDRAM_BUSY) begin
      pend.push_back('{addr: DDRAM_ADDR,
                       due: cyc + ((lat_fixed != 0) ? lat_fixed : int'($urandom_range(4, 1)))});
      rd_accepts++;
    end
    if (ddram_dout_ready) begin
      ready_cnt++;
      ready_cyc = cyc;
      if (exp_rd.size() == 0) check("spurious_ready", 128'(1), 128'(0));
      else check("rd_data", 128'(ddram_dout), 128'(exp_rd.pop_front()));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b1;
    ddram_we = 1'b0;
    ddram_rd = 1'b0;
    repeat (n) step();
    reset = 1'b0;
    exp_rd.delete();
    exp_wr.delete();
  endtask

  task automatic issue_write(input logic [28:0] a, input logic [63:0] d, input logic [7:0] b);
    ddram_we = 1'b1;
    ddram_addr = a;
    ddram_din = d;
    ddram_be = b;
    exp_wr.push_back('{addr: a, din: d, be: b});
    model_mem[a] = merge(model_rd(a), d, b);
  endtask

  task automatic wait_not_busy();
    int n;
    n = 0;
    while (ddram_busy && n < 300) begin step(); n++; end
    if (ddram_busy) check("busy_timeout", 128'(1), 128'(0));
  endtask

  task automatic do_write(input logic [28:0] a, input logic [63:0] d, input logic [7:0] b);
    wait_not_busy();
    issue_write(a, d, b);
    step();
    ddram_we = 1'b0;
  endtask

  task automatic do_read(input logic [28:0] a, input bit wr, input logic [63:0] d,
                         input logic [7:0] b, input bit chk_lat);
    int n;
    bit seen;
    if (wr) begin
      wait_not_busy();
      issue_write(a, d, b);
    end
    exp_rd.push_back(model_rd(a));
    ddram_rd = 1'b1;
    ddram_addr = a;
    step();
    ddram_we = 1'b0;
    if (chk_lat) check("rd_issue_lat", 128'(DDRAM_RD), 128'(1));
    n = 0;
    seen = 0;
    while (!ddram_dout_ready && n < 300) begin
      seen = seen | DDRAM_RD;
      if (seen) ddram_addr = 29'($urandom);
      step();
      n++;
    end
    if (!ddram_dout_ready) check("rd_timeout", 128'(0), 128'(1));
    else step();
    ddram_rd = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_wr.size() != 0 || ddram_busy) && n < 500) begin step(); n++; end
    check("drain_left", 128'(exp_wr.size()), 128'(0));
  endtask

  logic [7:0] be_pat [4] = '{8'h03, 8'h0C, 8'h30, 8'hC0};

  initial begin
    int base;
    int r0;
    logic [28:0] a;

    // Reset values.
    apply_reset(2);
    check("rst_dout", 128'(ddram_dout), 128'(0));
    check("rst_dout_ready", 128'(ddram_dout_ready), 128'(0));
    check("rst_busy", 128'(ddram_busy), 128'(0));
    check("rst_overflow", 128'(wr_overflow), 128'(0));
    check("rst_we", 128'(DDRAM_WE), 128'(0));
    check("rst_rd", 128'(DDRAM_RD), 128'(0));
    check("rst_addr", 128'(DDRAM_ADDR), 128'(0));
    check("rst_din", 128'(DDRAM_DIN), 128'(0));
    check("rst_be", 128'(DDRAM_BE), 128'(0));
    check("rst_burstcnt", 128'(DDRAM_BURSTCNT), 128'(1));
    step();
    check("rst_fifo_empty", 128'(DDRAM_WE), 128'(0));

    // Single read, memory answers three cycles after issue.
    busy_mode = 0;
    lat_fixed = 3;
    model_mem[29'h100] = 64'hDEADBEEF_01234567;
    slave_mem[29'h100] = 64'hDEADBEEF_01234567;
    rd_high_cnt = 0;
    do_read(29'h100, 1'b0, '0, '0, 1'b1);
    check("rd_ready_lat", 128'(ready_cyc), 128'(slave_rdy_cyc + 1));
    check("rd_single_strobe", 128'(rd_high_cnt), 128'(1));
    check("rd_latched_value", 128'(ddram_dout), 128'(64'hDEADBEEF_01234567));

    // Loader burst: a write every second cycle.
    for (int i = 0; i < 64; i++) begin
      issue_write(29'h1000 + 29'(i), {$urandom, $urandom}, be_pat[i % 4]);
      step();
      if (i == 0) check("push_to_we", 128'(DDRAM_WE), 128'(1));
      ddram_we = 1'b0;
      step();
    end
    wait_drain();
    check("burst_overflow", 128'(wr_overflow), 128'(0));

    // Ordering: write then read of the same address, and both in one cycle.
    lat_fixed = 2;
    do_write(29'h10, 64'h1122_3344_5566_7788, 8'hFF);
    do_read(29'h10, 1'b0, '0, '0, 1'b0);
    do_read(29'h20, 1'b1, 64'hCAFE_F00D_0BAD_BEEF, 8'h5A, 1'b0);

    // Random traffic against the memory model.
    busy_mode = 1;
    lat_fixed = 0;
    for (int i = 0; i < 200; i++) begin
      a = 29'h200 + 29'($urandom_range(7));
      case ($urandom_range(9))
        0, 1, 2, 3, 4, 5: do_write(a, {$urandom, $urandom}, 8'($urandom_range(255)));
        6:                do_read(a, 1'b1, {$urandom, $urandom}, 8'($urandom_range(255)), 1'b0);
        default:          do_read(a, 1'b0, '0, '0, 1'b0);
      endcase
      repeat ($urandom_range(2)) step();
    end
    wait_drain();
    check("rand_overflow", 128'(wr_overflow), 128'(0));

    // Back-pressure: memory stalls while writes stream in every cycle.
    apply_reset(1);
    busy_mode = 2;
    step();
    for (int i = 0; i < 5; i++) begin
      if (exp_wr.size() < DEPTH) begin
        issue_write(29'h300 + 29'(i), {$urandom, $urandom}, be_pat[i % 4]);
      end else begin
        ddram_we = 1'b1;
        ddram_addr = 29'h300 + 29'(i);
        ddram_din = {$urandom, $urandom};
      end
      step();
    end
    ddram_we = 1'b0;
    check("bp_busy", 128'(ddram_busy), 128'(1));
    check("bp_overflow", 128'(wr_overflow), 128'(1));
    check("bp_we_held", 128'(DDRAM_WE), 128'(1));
    repeat (14) step();
    check("bp_busy_hold", 128'(ddram_busy), 128'(1));
    busy_mode = 0;
    wait_drain();
    check("bp_overflow_sticky", 128'(wr_overflow), 128'(1));
    apply_reset(1);
    check("bp_overflow_clr", 128'(wr_overflow), 128'(0));

    // Reset while a read is outstanding at the memory.
    lat_fixed = 8;
    base = rd_accepts;
    ddram_rd = 1'b1;
    ddram_addr = 29'h40;
    r0 = 0;
    while (rd_accepts == base && r0 < 50) begin step(); r0++; end
    check("mid_rd_issued", 128'(rd_accepts != base), 128'(1));
    step();
    step();
    reset = 1'b1;
    ddram_rd = 1'b0;
    step();
    reset = 1'b0;
    lat_fixed = 2;
    r0 = ready_cnt;
    do_read(29'h41, 1'b0, '0, '0, 1'b0);
    check("mid_rd_pulses", 128'(ready_cnt - r0), 128'(1));
    check("mid_rd_data", 128'(ddram_dout), 128'(model_rd(29'h41)));
    check("mid_rd_reads", 128'(rd_accepts - base), 128'(2));

    repeat (4) step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
